// File: rtl/sorting_engine_param.sv
// In-place selection sort over a 2**L x N register array with host load/readback port.
// Optional swap counter output enabled by defining SORT_STATS_EN.
module sorting_engine_param #(
  parameter int unsigned N = 8,
  parameter int unsigned L = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         WrInit,
  input  logic         Rd,
  input  logic [L-1:0] RAddr,
  input  logic [N-1:0] DataIn,
  input  logic         start,
  input  logic [L:0]   len,
  input  logic         desc,
`ifdef SORT_STATS_EN
  output logic [2*L-1:0] swap_cnt,
`endif
  output logic [N-1:0] DataOut,
  output logic         busy,
  output logic         done
);

  localparam int unsigned Depth = 2 ** L;

  typedef enum logic [2:0] {StIdle, StOuter, StInner, StSwap, StDone} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mem_q [Depth];
  logic [N-1:0]   mem_d [Depth];
  logic [L-1:0]   i_q, i_d, j_q, j_d, sel_q, sel_d;
  logic [L:0]     n_q, n_d;
  logic           desc_q, desc_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           busy_q, done_q;
  logic [2*L-1:0] cnt_q, cnt_d;
  logic [L:0]     eff_len;
  logic           host_ok;
  logic           take_j;

  assign eff_len = (len > (L+1)'(Depth)) ? (L+1)'(Depth) : len;
  // Host port stays locked until done has dropped, not merely until state is idle.
  assign host_ok = (state_q == StIdle) && !done_q;
  assign take_j  = desc_q ? (mem_q[j_q] > mem_q[sel_q]) : (mem_q[j_q] < mem_q[sel_q]);

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    i_d     = i_q;
    j_d     = j_q;
    sel_d   = sel_q;
    n_d     = n_q;
    desc_d  = desc_q;
    dout_d  = dout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (host_ok && WrInit) mem_d[RAddr] = DataIn;
        if (host_ok && Rd)     dout_d = mem_q[RAddr];
        if (start) begin
          n_d     = eff_len;
          desc_d  = desc;
          i_d     = '0;
          cnt_d   = '0;
          state_d = (eff_len < (L+1)'(2)) ? StDone : StOuter;
        end
      end
      StOuter: begin
        sel_d   = i_q;
        j_d     = i_q + 1'b1;
        state_d = StInner;
      end
      StInner: begin
        if (take_j) sel_d = j_q;
        if ({1'b0, j_q} == n_q - (L+1)'(1)) state_d = StSwap;
        else                                j_d = j_q + 1'b1;
      end
      StSwap: begin
        if (sel_q != i_q) begin
          mem_d[i_q]   = mem_q[sel_q];
          mem_d[sel_q] = mem_q[i_q];
          cnt_d        = cnt_q + 1'b1;
        end
        if ({1'b0, i_q} == n_q - (L+1)'(2)) begin
          state_d = StDone;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = StOuter;
        end
      end
      StDone: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs are registered from the current state, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      for (int k = 0; k < Depth; k++) mem_q[k] <= '0;
      i_q     <= '0;
      j_q     <= '0;
      sel_q   <= '0;
      n_q     <= '0;
      desc_q  <= 1'b0;
      dout_q  <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      i_q     <= i_d;
      j_q     <= j_d;
      sel_q   <= sel_d;
      n_q     <= n_d;
      desc_q  <= desc_d;
      dout_q  <= dout_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_q == StOuter) || (state_q == StInner) || (state_q == StSwap);
      done_q  <= (state_q == StDone);
    end
  end

  assign DataOut = dout_q;
  assign busy    = busy_q;
  assign done    = done_q;

`ifdef SORT_STATS_EN
  assign swap_cnt = cnt_q;
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_q;
`endif

endmodule

// File: tb/tb_sorting_engine_param.sv
// Directed, scoreboarded bench for sorting_engine_param (N=8, L=4).
module tb_sorting_engine_param;

  localparam int unsigned N = 8;
  localparam int unsigned L = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         WrInit = 1'b0;
  logic         Rd = 1'b0;
  logic [L-1:0] RAddr = '0;
  logic [N-1:0] DataIn = '0;
  logic         start = 1'b0;
  logic [L:0]   len = '0;
  logic         desc = 1'b0;
  logic [N-1:0] DataOut;
  logic         busy;
  logic         done;
`ifdef SORT_STATS_EN
  logic [2*L-1:0] swap_cnt;
`endif

  sorting_engine_param #(.N(N), .L(L)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .WrInit  (WrInit),
    .Rd      (Rd),
    .RAddr   (RAddr),
    .DataIn  (DataIn),
    .start   (start),
    .len     (len),
    .desc    (desc),
`ifdef SORT_STATS_EN
    .swap_cnt(swap_cnt),
`endif
    .DataOut (DataOut),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  int unsigned  n_pass = 0;
  int unsigned  n_total = 0;
  logic [N-1:0] model [16];
  logic [N-1:0] sb_q [$];
  logic [N-1:0] last_rd = '0;
  int           ref_vec [8] = '{45, 12, 78, 34, 56, 89, 23, 67};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wr(input int addr, input int data);
    @(negedge clk);
    WrInit = 1'b1; RAddr = L'(addr); DataIn = N'(data);
    @(negedge clk);
    WrInit = 1'b0;
    model[addr] = N'(data);
  endtask

  // Read with optional simultaneous write; expected value is the pre-write model word.
  task automatic rd(input string tag, input int addr, input bit also_wr, input int data);
    logic [N-1:0] exp;
    @(negedge clk);
    Rd = 1'b1; RAddr = L'(addr); WrInit = also_wr; DataIn = N'(data);
    sb_q.push_back(model[addr]);
    if (also_wr) model[addr] = N'(data);
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    last_rd = exp;
    chk(tag, 32'(DataOut), 32'(exp));
    @(negedge clk);
    Rd = 1'b0; WrInit = 1'b0;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < 16; a++) rd(tag, a, 1'b0, 0);
  endtask

  task automatic load_ref();
    for (int a = 0; a < 8; a++) wr(a, ref_vec[a]);
  endtask

  // Independent reference: bubble sort of the first n model words.
  task automatic msort(input int n, input bit d);
    logic [N-1:0] t;
    for (int p = 0; p < n; p++)
      for (int q = 0; q + 1 < n - p; q++)
        if (d ? (model[q] < model[q+1]) : (model[q] > model[q+1])) begin
          t = model[q]; model[q] = model[q+1]; model[q+1] = t;
        end
  endtask

  task automatic do_sort(input string tag, input int n_req, input bit d, input bit hold,
                         input bit poke);
    int n_eff, exp_lat, cyc;
    bit busy_seen;
    n_eff   = (n_req > 16) ? 16 : n_req;
    exp_lat = (n_eff < 2) ? 1 : 2 * (n_eff - 1) + n_eff * (n_eff - 1) / 2 + 1;
    cyc = 0; busy_seen = 1'b0;
    @(negedge clk);
    start = 1'b1; len = (L+1)'(n_req); desc = d;
    @(posedge clk);
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (busy) busy_seen = 1'b1;
      if (done) break;
      if (cyc > 1000) begin
        chk({tag, "_timeout"}, 32'(0), 32'(1));
        break;
      end
      if (poke && cyc == 5) begin
        @(negedge clk);
        WrInit = 1'b1; Rd = 1'b1; RAddr = '0; DataIn = 8'hFF;
      end
      if (poke && cyc == 6) begin
        @(negedge clk);
        WrInit = 1'b0; Rd = 1'b0;
      end
    end
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    chk({tag, "_busy_seen"}, 32'(busy_seen), 32'(n_eff >= 2));
    if (poke) chk({tag, "_dout_hold"}, 32'(DataOut), 32'(last_rd));
    if (hold) begin
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_done_hold"}, 32'(done), 32'(1));
    end
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_done_drop"}, 32'(done), 32'(0));
    msort(n_eff, d);
  endtask

  initial begin
    for (int a = 0; a < 16; a++) model[a] = '0;
    #12;
    rst_n = 1'b1;
    #1;
    chk("reset_dout", 32'(DataOut), 32'(0));
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_done", 32'(done), 32'(0));
    rd("reset_mem", 5, 1'b0, 0);

    // Read-before-write on the same address, then confirm the write landed.
    rd("rbw_old", 8, 1'b1, 99);
    rd("rbw_new", 8, 1'b0, 0);

    load_ref();
    do_sort("asc8", 8, 1'b0, 1'b1, 1'b0);
`ifdef SORT_STATS_EN
    chk("swap_cnt", 32'(swap_cnt), 32'(5));
`endif
    read_all("asc8_rd");

    load_ref();
    do_sort("desc8", 8, 1'b1, 1'b0, 1'b0);
    read_all("desc8_rd");

    for (int a = 0; a < 16; a++) wr(a, 15 - a);
    do_sort("part5", 5, 1'b0, 1'b0, 1'b0);
    read_all("part5_rd");

    do_sort("len0", 0, 1'b0, 1'b0, 1'b0);
    read_all("len0_rd");
    do_sort("len1", 1, 1'b1, 1'b0, 1'b0);
    read_all("len1_rd");

    for (int a = 0; a < 16; a++) wr(a, $urandom_range(0, 255));
    do_sort("len20", 20, 1'b0, 1'b0, 1'b0);
    read_all("len20_rd");

    wr(0, 7); wr(1, 7); wr(2, 3); wr(3, 7);
    do_sort("dup", 4, 1'b0, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) rd("dup_rd", a, 1'b0, 0);

    // Host strobes during the sort must not disturb the array or DataOut.
    load_ref();
    rd("pre_poke", 3, 1'b0, 0);
    do_sort("poke", 8, 1'b1, 1'b0, 1'b1);
    read_all("poke_rd");

    // Asynchronous reset while the sort is in its inner loop.
    rd("pre_rst", 2, 1'b0, 0);
    @(negedge clk);
    start = 1'b1; len = 5'd8; desc = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_dout", 32'(DataOut), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    for (int a = 0; a < 16; a++) model[a] = '0;
    read_all("rst_rd");

    load_ref();
    do_sort("after_rst", 8, 1'b0, 1'b0, 1'b0);
    read_all("after_rst_rd");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sorting_engine_param.md
Name: sorting_engine_param

Overview:
- Parametrised successor to the fixed 8-entry sorting_top. On-chip register array of DEPTH = 2**L words, N bits each.
- Host loads words through a write port, then pulses start. An in-place selection-sort FSM orders the first len entries, ascending or descending per desc. Results are read back through a registered read port.
- Sits between the host test/control logic and downstream consumers of sorted key lists.

Parameters:
- N, 8, data word width in bits.
- L, 4, address width; array depth DEPTH = 2**L.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- WrInit  input  1  write strobe; writes DataIn to array[RAddr] at clk edge when idle.
- Rd  input  1  read strobe; DataOut <= array[RAddr] at clk edge when idle.
- RAddr  input  L  shared read/write address.
- DataIn  input  N  write data.
- start  input  1  sort request, level-sampled in IDLE.
- len  input  L+1  number of entries to sort, counted from address 0. Sampled with start.
- desc  input  1  0 = ascending, 1 = descending. Sampled with start.
- DataOut  output  N  registered read data.
- busy  output  1  high while sorting (OUTER/INNER/SWAP).
- done  output  1  high in DONE state.

Behaviour:
- Reset, asynchronous on rst_n low: state = IDLE; DataOut = 0; busy = 0; done = 0; all array words = 0; internal indices = 0.
- Sort length: eff_len = min(len, DEPTH), latched together with desc on the start-sampling edge.
- IDLE:
  - WrInit and Rd are honoured.
  - If WrInit and Rd are both high, the write occurs, and DataOut returns the old word (read-before-write).
  - start = 1 → if eff_len < 2 go to DONE, else go to OUTER with i = 0.
- OUTER: sel = i, j = i+1 → INNER.
- INNER, one comparison per cycle:
  - Ascending: sel <= j if array[j] < array[sel].
  - Descending: sel <= j if array[j] > array[sel].
  - Compare is unsigned and strict, so ties never move sel.
  - If j == eff_len-1 → SWAP, else j++.
- SWAP:
  - If sel != i, exchange array[i] and array[sel] in one cycle; otherwise no write. The cycle is spent either way.
  - If i == eff_len-2 → DONE, else i++ and → OUTER.
- DONE: done = 1 and busy = 0; stays until start is seen low, then → IDLE. done is a level, not a pulse.
- Busy window:
  - busy = 1 exactly in OUTER/INNER/SWAP.
  - WrInit and Rd are ignored while busy or done; DataOut holds its last value.
  - start, len and desc changes are ignored until IDLE.
- Latency:
  - T(n) = 2(n-1) + n(n-1)/2 busy cycles for n = eff_len ≥ 2.
  - done rises on the edge T+1 cycles after the start-sampling edge.
  - For eff_len < 2, done rises 1 cycle after that edge.
- Entries at addresses ≥ eff_len are never read or written by the sort.
- rst_n asserted mid-sort: immediate return to IDLE, array cleared, outputs at reset values. No partial result is guaranteed.
- Read latency: 1 cycle (address and Rd on edge k, DataOut valid after edge k).

Optional Feature:
- Macro SORT_STATS_EN.
- When defined:
  - Adds output swap_cnt, width 2L. Cleared on reset and on each start acceptance.
  - Increments on every SWAP cycle that performs an exchange (sel != i).
  - Holds its value through DONE and IDLE.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Ascending sort, reference vector: load 45,12,78,34,56,89,23,67 at 0..7, len = 8, desc = 0, start → done rises 43 cycles after the start edge (T = 42). Readback 12,23,34,45,56,67,78,89. With SORT_STATS_EN, swap_cnt = 5.
- Descending sort: same load, desc = 1 → readback 89,78,67,56,45,34,23,12.
- Partial length: load 16 words 15..0, len = 5, desc = 0 → addr 0..4 = 11,12,13,14,15; addr 5..15 unchanged (10..0); T = 18.
- Degenerate lengths:
  - len = 0 → done after 1 cycle, busy never rises, array unchanged.
  - len = 1 → same.
  - len = 20 → clamps to 16; full-array sort.
  - Duplicates: 7,7,3,7 → 3,7,7,7.
- Interlocks and reset: WrInit and Rd pulsed while busy → array and DataOut unaffected. rst_n dropped mid-INNER → all outputs 0 at once, array cleared. A new load+sort afterwards completes correctly. Holding start high keeps done = 1; deasserting start returns to IDLE.
